// File: rtl/vip_yuv422to444_if.sv
// ---------------------------------------------------------------------------
// vip_yuv422to444_if
//
// Video bus for the 4:2:2 -> 4:4:4 chroma upsampler.
//
// Stream semantics: in_href / out_href act as a valid qualifier with no
// ready. One pixel is transferred on every rising pclk edge where href is
// high. The sink can never stall the source.
//
// Signals
//   switch_uv : chroma order select. 0 = first chroma of a pair is U.
//   in_href   : input line valid
//   in_vsync  : input frame sync
//   in_y      : input luma            [BITS]
//   in_c      : input muxed chroma    [BITS]
//   out_href  : output line valid
//   out_vsync : output frame sync
//   out_y/u/v : output 4:4:4 pixel    [BITS each]
//
// Modports
//   master : pixel source / sink side (drives in_*, reads out_*)
//   slave  : the upsampler (reads in_*, drives out_*)
// ---------------------------------------------------------------------------
interface vip_yuv422to444_if #(
    parameter int BITS = 8
);
    logic            switch_uv;
    logic            in_href;
    logic            in_vsync;
    logic [BITS-1:0] in_y;
    logic [BITS-1:0] in_c;
    logic            out_href;
    logic            out_vsync;
    logic [BITS-1:0] out_y;
    logic [BITS-1:0] out_u;
    logic [BITS-1:0] out_v;

    modport master (
        output switch_uv, in_href, in_vsync, in_y, in_c,
        input  out_href, out_vsync, out_y, out_u, out_v
    );

    modport slave (
        input  switch_uv, in_href, in_vsync, in_y, in_c,
        output out_href, out_vsync, out_y, out_u, out_v
    );
endinterface

// File: rtl/vip_yuv422to444.sv
// ---------------------------------------------------------------------------
// vip_yuv422to444
//
// Chroma upsampler at the VIP pipeline input. It converts a YUV 4:2:2 stream
// (one luma and one alternating chroma sample per pclk) into a 4:4:4 stream.
// The latency is a fixed 3 cycles for href, vsync and pixel data.
//
// Build option
//   VIP_YUV422TO444_INTERP_EN : when defined, odd pixels get the rounded mean
//                               of the current and next chroma pair. When
//                               undefined, odd pixels repeat the current pair
//                               and no averaging logic is built.
//
// Ports
//   pclk : pixel clock, rising edge
//   rst  : synchronous reset, active high
//   vid  : vip_yuv422to444_if.slave
//          inputs  switch_uv, in_href, in_vsync, in_y, in_c
//          outputs out_href, out_vsync, out_y, out_u, out_v
//
// Datapath
//   Inputs go through a 4-deep delay line. Stage 3 holds the pixel being
//   output (p). Stage 4 holds p-1, stage 2 holds p+1 and stage 1 holds p+2.
//   Interpolation therefore sees both chroma samples of the next pair
//   without adding latency. Each stage carries an "act" flag. Two adjacent
//   stages that are both active always belong to the same href run, so
//   neighbours from another line or from across blanking are never used.
// ---------------------------------------------------------------------------
module vip_yuv422to444 #(
    parameter int BITS   = 8,
    parameter int WIDTH  = 1280,
    parameter int HEIGHT = 960
) (
    input  logic                  pclk,
    input  logic                  rst,
    vip_yuv422to444_if.slave      vid
);

    // Nominal frame geometry. These values are informational only. The
    // datapath handles any line length of one pixel or more.
    if (WIDTH >= 1 && HEIGHT >= 1) begin : g_geometry
    end

    localparam logic [BITS-1:0] MID = {1'b1, {(BITS-1){1'b0}}};

    // Line tracking.
    // armed: a non-reset href=0 sample has been seen since the last reset,
    //        so the next rising href starts a complete line.
    logic armed;
    logic href_prev;
    logic phase;
    logic sw_line;
    logic act_in;
    logic sw_cur;

    // Delay line (index = stages since sampling).
    logic [BITS-1:0] c_d [1:4];
    logic [BITS-1:0] y_d [1:3];
    logic [4:1]      act_d;
    logic [3:1]      ph_d;
    logic [3:1]      sw_d;
    logic [3:1]      vs_d;

    // Chroma selection for the pixel in stage 3.
    logic [BITS-1:0] first_k;
    logic [BITS-1:0] second_k;
    logic [BITS-1:0] pix_a;
    logic [BITS-1:0] pix_b;
    logic [BITS-1:0] u_nxt;
    logic [BITS-1:0] v_nxt;

    assign act_in = vid.in_href & armed;
    // switch_uv is taken on the first pixel of a line and held for the
    // rest of that line.
    assign sw_cur = (vid.in_href && !href_prev) ? vid.switch_uv : sw_line;

    // first_k / second_k are the two chroma samples of the pair that owns
    // the stage-3 pixel, in arrival order.
    always_comb begin
        first_k  = c_d[3];
        second_k = MID;
        if (ph_d[3]) begin
            first_k  = c_d[4];
            second_k = c_d[3];
        end else if (act_d[2]) begin
            second_k = c_d[2];
        end else if (act_d[4]) begin
            // Last pixel of an odd-length line: reuse the previous pair's
            // second sample. On a one-pixel line fall back to midscale.
            second_k = c_d[4];
        end
    end

`ifdef VIP_YUV422TO444_INTERP_EN
    logic [BITS-1:0] next_first;
    logic [BITS-1:0] next_second;

    function automatic logic [BITS-1:0] avg(input logic [BITS-1:0] a,
                                            input logic [BITS-1:0] b);
        logic [BITS:0] s;
        s = {1'b0, a} + {1'b0, b} + {{BITS{1'b0}}, 1'b1};
        return BITS'(s >> 1);
    endfunction

    // The next pair only counts when it is in the same run. A missing
    // sample falls back to the current pair's sample.
    always_comb begin
        next_first  = act_d[2] ? c_d[2] : first_k;
        next_second = (act_d[2] && act_d[1]) ? c_d[1] : second_k;
        pix_a       = first_k;
        pix_b       = second_k;
        if (ph_d[3]) begin
            pix_a = avg(first_k, next_first);
            pix_b = avg(second_k, next_second);
        end
    end
`else
    assign pix_a = first_k;
    assign pix_b = second_k;
`endif

    assign u_nxt = sw_d[3] ? pix_b : pix_a;
    assign v_nxt = sw_d[3] ? pix_a : pix_b;

    always_ff @(posedge pclk) begin
        if (rst) begin
            armed     <= 1'b0;
            href_prev <= 1'b0;
            phase     <= 1'b0;
            sw_line   <= 1'b0;
            for (int i = 1; i <= 4; i++) c_d[i] <= '0;
            for (int i = 1; i <= 3; i++) y_d[i] <= '0;
            act_d         <= '0;
            ph_d          <= '0;
            sw_d          <= '0;
            vs_d          <= '0;
            vid.out_href  <= 1'b0;
            vid.out_vsync <= 1'b0;
            vid.out_y     <= '0;
            vid.out_u     <= '0;
            vid.out_v     <= '0;
        end else begin
            armed     <= armed | ~vid.in_href;
            href_prev <= vid.in_href;
            phase     <= vid.in_href ? ~phase : 1'b0;
            sw_line   <= sw_cur;

            c_d[1] <= vid.in_c;
            c_d[2] <= c_d[1];
            c_d[3] <= c_d[2];
            c_d[4] <= c_d[3];
            y_d[1] <= vid.in_y;
            y_d[2] <= y_d[1];
            y_d[3] <= y_d[2];
            act_d  <= {act_d[3:1], act_in};
            ph_d   <= {ph_d[2:1], phase};
            sw_d   <= {sw_d[2:1], sw_cur};
            vs_d   <= {vs_d[2:1], vid.in_vsync};

            vid.out_href  <= act_d[3];
            vid.out_vsync <= vs_d[3];
            vid.out_y     <= act_d[3] ? y_d[3] : '0;
            vid.out_u     <= act_d[3] ? u_nxt  : '0;
            vid.out_v     <= act_d[3] ? v_nxt  : '0;
        end
    end

endmodule

// File: tb/tb_vip_yuv422to444.sv
// ---------------------------------------------------------------------------
// tb_vip_yuv422to444
//
// Bench for vip_yuv422to444. It builds the full stimulus program up front:
// directed lines followed by random lines, random blanking and random reset
// pulses. A line-level reference model then derives the expected output
// stream from the chroma rules. The driver replays the program one cycle
// per pclk, and a compare process checks every output edge against the
// expected queue and against hand-computed literal pixels.
// ---------------------------------------------------------------------------
module tb_vip_yuv422to444;

    localparam int BITS = 8;
    localparam int MAXC = 4096;
    localparam int PW   = 3 * BITS + 2;
    localparam logic [BITS-1:0] MID = BITS'(1 << (BITS - 1));
`ifdef VIP_YUV422TO444_INTERP_EN
    localparam bit INTERP = 1'b1;
`else
    localparam bit INTERP = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic pclk = 1'b0;
    logic rst;
    always #5 pclk = ~pclk;

    vip_yuv422to444_if #(.BITS(BITS)) vid ();

    vip_yuv422to444 #(.BITS(BITS), .WIDTH(1280), .HEIGHT(960)) dut (
        .pclk (pclk),
        .rst  (rst),
        .vid  (vid)
    );

    // ---------------- stimulus program ----------------
    logic            s_rst  [MAXC];
    logic            s_href [MAXC];
    logic            s_vs   [MAXC];
    logic            s_sw   [MAXC];
    logic [BITS-1:0] s_y    [MAXC];
    logic [BITS-1:0] s_c    [MAXC];
    int              ncyc = 0;

    // ---------------- expected stream ----------------
    logic            e_href [MAXC];
    logic            e_vs   [MAXC];
    logic [BITS-1:0] e_y    [MAXC];
    logic [BITS-1:0] e_u    [MAXC];
    logic [BITS-1:0] e_v    [MAXC];
    logic [PW-1:0]   exp_q [$];

    typedef struct {
        int            cyc;
        logic [PW-1:0] val;
    } lit_t;
    lit_t lit_q [$];

    int n_checks = 0;
    int n_fail   = 0;
    int edge_idx = 0;
    bit running  = 1'b0;

    // ---------------- driver tasks ----------------
    task automatic put(input logic r, input logic h, input logic vs, input logic sw,
                       input logic [BITS-1:0] y, input logic [BITS-1:0] c);
        s_rst[ncyc]  = r;
        s_href[ncyc] = h;
        s_vs[ncyc]   = vs;
        s_sw[ncyc]   = sw;
        s_y[ncyc]    = y;
        s_c[ncyc]    = c;
        ncyc++;
    endtask

    task automatic pix(input logic sw, input logic [BITS-1:0] y, input logic [BITS-1:0] c);
        put(1'b0, 1'b1, 1'b0, sw, y, c);
    endtask

    task automatic gap(input int n);
        repeat (n) put(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    // Expected output for the input sampled at cycle pc (seen at pc+3).
    task automatic lit(input int pc, input logic h, input logic vs,
                       input logic [BITS-1:0] y, input logic [BITS-1:0] u,
                       input logic [BITS-1:0] v);
        lit_t e;
        e.cyc = pc + 3;
        e.val = {h, vs, y, u, v};
        lit_q.push_back(e);
    endtask

    function automatic logic [BITS-1:0] mean(input logic [BITS-1:0] a, input logic [BITS-1:0] b);
        int s;
        s = (int'(a) + int'(b) + 1) / 2;
        return BITS'(s);
    endfunction

    // ---------------- reference model ----------------
    // Works line by line: collects the chroma samples of each complete href
    // run, forms the (first, second) chroma pairs with the missing-sample
    // rules, and places each output pixel 3 cycles after its input.
    // Any reset inside the 3-cycle window forces that output edge to zero.
    task automatic build_model();
        logic [BITS-1:0] cs [64];
        logic [BITS-1:0] fk [32];
        logic [BITS-1:0] sk [32];
        logic [BITS-1:0] a, b, nf, ns;
        int len, np, k;
        bit hit;
        for (int n = 0; n < ncyc; n++) begin
            e_href[n] = 1'b0;
            e_vs[n]   = (n >= 3) ? s_vs[n-3] : 1'b0;
            e_y[n]    = '0;
            e_u[n]    = '0;
            e_v[n]    = '0;
        end
        for (int t = 1; t < ncyc; t++) begin
            if (s_href[t] && !s_href[t-1] && !s_rst[t-1]) begin
                len = 0;
                while (t + len < ncyc && len < 64 && s_href[t+len] && !s_rst[t+len]) begin
                    cs[len] = s_c[t+len];
                    len++;
                end
                np = (len + 1) / 2;
                for (int p = 0; p < np; p++) begin
                    fk[p] = cs[2*p];
                    if (2*p + 1 < len)  sk[p] = cs[2*p+1];
                    else if (p > 0)     sk[p] = sk[p-1];
                    else                sk[p] = MID;
                end
                for (int i = 0; i < len; i++) begin
                    k = i / 2;
                    a = fk[k];
                    b = sk[k];
                    if (INTERP && (i % 2 == 1)) begin
                        nf = (k + 1 < np) ? fk[k+1] : fk[k];
                        ns = (k + 1 < np) ? sk[k+1] : sk[k];
                        a  = mean(a, nf);
                        b  = mean(b, ns);
                    end
                    if (t + i + 3 < ncyc) begin
                        e_href[t+i+3] = 1'b1;
                        e_y[t+i+3]    = s_y[t+i];
                        e_u[t+i+3]    = s_sw[t] ? b : a;
                        e_v[t+i+3]    = s_sw[t] ? a : b;
                    end
                end
            end
        end
        for (int n = 0; n < ncyc; n++) begin
            hit = 1'b0;
            for (int m = n - 3; m <= n; m++)
                if (m >= 0 && s_rst[m]) hit = 1'b1;
            if (hit) begin
                e_href[n] = 1'b0;
                e_vs[n]   = 1'b0;
                e_y[n]    = '0;
                e_u[n]    = '0;
                e_v[n]    = '0;
            end
            exp_q.push_back({e_href[n], e_vs[n], e_y[n], e_u[n], e_v[n]});
        end
    endtask

    // ---------------- stimulus construction ----------------
    task automatic build_stimulus();
        int b;
        int g;
        int len;
        logic sw0;
        // Reset, then idle.
        repeat (3) put(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
        gap(2);

        // Line A: 4 pixels, switch_uv=0.
        b = ncyc;
        pix(0, 10, 100); pix(0, 20, 200); pix(0, 30, 110); pix(0, 40, 210);
        lit(b,   1, 0, 10, 100, 200);
        lit(b+1, 1, 0, 20, INTERP ? 8'd105 : 8'd100, INTERP ? 8'd205 : 8'd200);
        lit(b+2, 1, 0, 30, 110, 210);
        lit(b+3, 1, 0, 40, 110, 210);
        // One-cycle blanking gap; out_href must show the same gap.
        lit(b+4, 0, 0, 0, 0, 0);
        gap(1);

        // Line B: no averaging with line A.
        b = ncyc;
        pix(0, 1, 50); pix(0, 2, 60); pix(0, 3, 70); pix(0, 4, 80);
        lit(b,   1, 0, 1, 50, 60);
        lit(b+1, 1, 0, 2, INTERP ? 8'd60 : 8'd50, INTERP ? 8'd70 : 8'd60);
        lit(b+3, 1, 0, 4, 70, 80);
        gap(2);

        // Odd-length line.
        b = ncyc;
        pix(0, 5, 100); pix(0, 6, 200); pix(0, 7, 110);
        lit(b,   1, 0, 5, 100, 200);
        lit(b+1, 1, 0, 6, INTERP ? 8'd105 : 8'd100, 200);
        lit(b+2, 1, 0, 7, 110, 200);
        gap(1);

        // Single-pixel line: missing V is midscale.
        b = ncyc;
        pix(0, 9, 100);
        lit(b, 1, 0, 9, 100, MID);
        gap(1);

        // switch_uv=1 at line start, toggled mid-line.
        b = ncyc;
        pix(1, 11, 200); pix(0, 12, 100);
        lit(b,   1, 0, 11, 100, 200);
        lit(b+1, 1, 0, 12, 100, 200);
        gap(1);
        b = ncyc;
        pix(0, 13, 30); pix(1, 14, 40);
        lit(b, 1, 0, 13, 30, 40);
        gap(1);

        // Full-scale chroma.
        b = ncyc;
        repeat (4) pix(0, 255, 255);
        lit(b+1, 1, 0, 255, 255, 255);
        lit(b+3, 1, 0, 255, 255, 255);
        gap(1);

        // Rounding at the low end.
        b = ncyc;
        pix(0, 21, 0); pix(0, 22, 0); pix(0, 23, 1); pix(0, 24, 1);
        lit(b+1, 1, 0, 22, INTERP ? 8'd1 : 8'd0, INTERP ? 8'd1 : 8'd0);
        gap(2);

        // vsync pulse: edge appears exactly 3 cycles later.
        b = ncyc;
        lit(b-1, 0, 0, 0, 0, 0);
        put(0, 0, 1, 0, 0, 0); put(0, 0, 1, 0, 0, 0);
        lit(b,   0, 1, 0, 0, 0);
        lit(b+2, 0, 0, 0, 0, 0);
        gap(2);

        // Reset at pixel 2 of a line; the rest of that line is dropped.
        b = ncyc;
        pix(0, 31, 60); pix(0, 32, 61);
        put(1, 1, 0, 0, 33, 62);
        pix(0, 34, 63); pix(0, 35, 64); pix(0, 36, 65);
        lit(b,   0, 0, 0, 0, 0);
        lit(b+1, 0, 0, 0, 0, 0);
        lit(b+3, 0, 0, 0, 0, 0);
        lit(b+5, 0, 0, 0, 0, 0);
        gap(1);
        b = ncyc;
        pix(0, 41, 100); pix(0, 42, 200); pix(0, 43, 110); pix(0, 44, 210);
        lit(b,   1, 0, 41, 100, 200);
        lit(b+2, 1, 0, 43, 110, 210);
        lit(b+3, 1, 0, 44, 110, 210);
        gap(3);

        // Random lines, blanking, vsync and resets.
        for (int l = 0; l < 80; l++) begin
            g = $urandom_range(1, 4);
            for (int i = 0; i < g; i++)
                put(1'($urandom_range(0, 50) == 0), 1'b0, 1'($urandom_range(0, 3) == 0),
                    1'($urandom_range(0, 1)), BITS'($urandom_range(0, 255)),
                    BITS'($urandom_range(0, 255)));
            len = $urandom_range(1, 24);
            sw0 = 1'($urandom_range(0, 1));
            for (int i = 0; i < len; i++)
                put(1'($urandom_range(0, 60) == 0), 1'b1, 1'($urandom_range(0, 7) == 0),
                    (i == 0) ? sw0 : 1'($urandom_range(0, 1)),
                    BITS'($urandom_range(0, 255)),
                    ($urandom_range(0, 3) == 0) ? BITS'(255) : BITS'($urandom_range(0, 255)));
        end
        gap(6);
    endtask

    // ---------------- scoreboard / compare ----------------
    always @(negedge pclk) begin
        logic [PW-1:0] got;
        logic [PW-1:0] want;
        lit_t          e;
        if (running) begin
            got = {vid.out_href, vid.out_vsync, vid.out_y, vid.out_u, vid.out_v};
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL out cyc%0d scoreboard empty got=%h", edge_idx, got);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    n_fail++;
                    $display("FAIL out cyc%0d got href=%b vs=%b y=%0d u=%0d v=%0d want href=%b vs=%b y=%0d u=%0d v=%0d",
                             edge_idx, got[PW-1], got[PW-2], got[3*BITS-1:2*BITS], got[2*BITS-1:BITS], got[BITS-1:0],
                             want[PW-1], want[PW-2], want[3*BITS-1:2*BITS], want[2*BITS-1:BITS], want[BITS-1:0]);
                end
            end
            while (lit_q.size() > 0 && lit_q[0].cyc == edge_idx) begin
                e = lit_q.pop_front();
                n_checks++;
                if (got !== e.val) begin
                    n_fail++;
                    $display("FAIL lit cyc%0d got=%h want=%h", edge_idx, got, e.val);
                end
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [PW-1:0] m;
        rst           = 1'b1;
        vid.switch_uv = 1'b0;
        vid.in_href   = 1'b0;
        vid.in_vsync  = 1'b0;
        vid.in_y      = '0;
        vid.in_c      = '0;

        build_stimulus();
        build_model();

        // Pin the model itself against the hand-computed pixels.
        for (int i = 0; i < lit_q.size(); i++) begin
            n_checks++;
            if (lit_q[i].cyc >= ncyc) begin
                n_fail++;
                $display("FAIL model lit %0d beyond program end", i);
            end else begin
                m = {e_href[lit_q[i].cyc], e_vs[lit_q[i].cyc], e_y[lit_q[i].cyc],
                     e_u[lit_q[i].cyc], e_v[lit_q[i].cyc]};
                if (m !== lit_q[i].val) begin
                    n_fail++;
                    $display("FAIL model cyc%0d got=%h want=%h", lit_q[i].cyc, m, lit_q[i].val);
                end
            end
        end

        for (int n = 0; n < ncyc; n++) begin
            rst           = s_rst[n];
            vid.in_href   = s_href[n];
            vid.in_vsync  = s_vs[n];
            vid.switch_uv = s_sw[n];
            vid.in_y      = s_y[n];
            vid.in_c      = s_c[n];
            @(posedge pclk);
            edge_idx = n;
            running  = 1'b1;
            #1;
        end
        @(negedge pclk);
        #1;
        running = 1'b0;

        if (lit_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL lit %0d literal checks never reached", lit_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
